// File: rtl/expr_eval.sv
// expr_eval: streaming evaluator for single-digit '+' / '*' expressions
// terminated by '='. '*' binds tighter than '+'. Arithmetic wraps modulo
// 2^WIDTH. A malformed expression locks the block in an error state until clr.
module expr_eval #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [7:0]       in,
  output logic [WIDTH-1:0] result,
  output logic             done,
  output logic             error
);

  typedef enum logic [1:0] {
    S_NUM  = 2'd0,
    S_OP   = 2'd1,
    S_DONE = 2'd2,
    S_ERR  = 2'd3
  } state_t;

  localparam logic [WIDTH-1:0] VAL_ZERO = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] VAL_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  // Character classification helpers
  function automatic logic is_digit(input logic [7:0] c);
    return (c >= 8'h30) && (c <= 8'h39);
  endfunction

  function automatic logic [WIDTH-1:0] digit_val(input logic [7:0] c);
    // Low nibble of an ASCII digit equals its value.
    return {{(WIDTH-4){1'b0}}, c[3:0]};
  endfunction

  state_t           state_r, state_nxt_s;
  logic [WIDTH-1:0] sum_r, sum_nxt_s;
  logic [WIDTH-1:0] term_r, term_nxt_s;
  logic [WIDTH-1:0] result_r, result_nxt_s;
  logic             done_r, done_nxt_s;
  logic             error_r, error_nxt_s;

  logic             is_digit_s;
  logic             is_plus_s;
  logic             is_mul_s;
  logic             is_eq_s;

  // Decode the incoming character
  always_comb begin
    is_digit_s = is_digit(in);
    is_plus_s  = (in == 8'h2B);
    is_mul_s   = (in == 8'h2A);
    is_eq_s    = (in == 8'h3D);
  end

  // Next-state and datapath update; everything holds when no character arrives
  always_comb begin
    state_nxt_s  = state_r;
    sum_nxt_s    = sum_r;
    term_nxt_s   = term_r;
    result_nxt_s = result_r;
    done_nxt_s   = done_r;
    error_nxt_s  = error_r;

    if (in_valid) begin
      case (state_r)
        S_NUM: begin
          if (is_digit_s) begin
            term_nxt_s  = term_r * digit_val(in);
            state_nxt_s = S_OP;
          end else begin
            state_nxt_s = S_ERR;
            error_nxt_s = 1'b1;
            done_nxt_s  = 1'b0;
          end
        end
        S_OP: begin
          if (is_mul_s) begin
            state_nxt_s = S_NUM;
          end else if (is_plus_s) begin
            sum_nxt_s   = sum_r + term_r;
            term_nxt_s  = VAL_ONE;
            state_nxt_s = S_NUM;
          end else if (is_eq_s) begin
            result_nxt_s = sum_r + term_r;
            done_nxt_s   = 1'b1;
            sum_nxt_s    = VAL_ZERO;
            term_nxt_s   = VAL_ONE;
            state_nxt_s  = S_DONE;
          end else begin
            state_nxt_s = S_ERR;
            error_nxt_s = 1'b1;
            done_nxt_s  = 1'b0;
          end
        end
        S_DONE: begin
          if (is_digit_s) begin
            // First digit of the next expression; accumulators were
            // reinitialised when '=' was accepted.
            done_nxt_s  = 1'b0;
            sum_nxt_s   = VAL_ZERO;
            term_nxt_s  = digit_val(in);
            state_nxt_s = S_OP;
          end else begin
            state_nxt_s = S_ERR;
            error_nxt_s = 1'b1;
            done_nxt_s  = 1'b0;
          end
        end
        S_ERR: begin
          // Locked until clr; input is ignored.
          state_nxt_s = S_ERR;
        end
        default: begin
          state_nxt_s = S_ERR;
          error_nxt_s = 1'b1;
          done_nxt_s  = 1'b0;
        end
      endcase
    end else begin
      state_nxt_s  = state_r;
      sum_nxt_s    = sum_r;
      term_nxt_s   = term_r;
      result_nxt_s = result_r;
      done_nxt_s   = done_r;
      error_nxt_s  = error_r;
    end
  end

  // State and datapath registers with asynchronous clear
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_r  <= S_NUM;
      sum_r    <= VAL_ZERO;
      term_r   <= VAL_ONE;
      result_r <= VAL_ZERO;
      done_r   <= 1'b0;
      error_r  <= 1'b0;
    end else begin
      state_r  <= state_nxt_s;
      sum_r    <= sum_nxt_s;
      term_r   <= term_nxt_s;
      result_r <= result_nxt_s;
      done_r   <= done_nxt_s;
      error_r  <= error_nxt_s;
    end
  end

  assign result = result_r;
  assign done   = done_r;
  assign error  = error_r;

endmodule
